// File: rtl/bcc_pkg.sv
// bcc_pkg: shared definitions for the branch condition evaluator.
//   - COND_*  : 4-bit ARM-style condition codes carried in branch instructions.
//   - FLAG_*  : bit positions of the status flags inside the packed {Z,C,N,V}
//               vector. These same positions are used by the ALU flag writer.
package bcc_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;  // Z
   localparam logic [3:0] COND_NE = 4'b0001;  // !Z
   localparam logic [3:0] COND_CS = 4'b0010;  // C
   localparam logic [3:0] COND_CC = 4'b0011;  // !C
   localparam logic [3:0] COND_MI = 4'b0100;  // N
   localparam logic [3:0] COND_PL = 4'b0101;  // !N
   localparam logic [3:0] COND_VS = 4'b0110;  // V
   localparam logic [3:0] COND_VC = 4'b0111;  // !V
   localparam logic [3:0] COND_HI = 4'b1000;  // C & !Z
   localparam logic [3:0] COND_LS = 4'b1001;  // !C | Z
   localparam logic [3:0] COND_GE = 4'b1010;  // N == V
   localparam logic [3:0] COND_LT = 4'b1011;  // N != V
   localparam logic [3:0] COND_GT = 4'b1100;  // !Z & (N == V)
   localparam logic [3:0] COND_LE = 4'b1101;  // Z | (N != V)
   localparam logic [3:0] COND_AL = 4'b1110;  // always
   localparam logic [3:0] COND_NV = 4'b1111;  // build-time choice (NV_TAKEN)

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/bcc_cond_eval.sv
// bcc_cond_eval: combinational branch condition evaluation.
// Ports:
//   flags       in  [3:0] status flags packed {Z,C,N,V}
//   branch_cond in  [3:0] condition field of the branch instruction
//   taken       out       1 when the condition holds for the given flags
// Parameter:
//   NV_TAKEN    result for the NV code (0: never taken, 1: unconditional)
module bcc_cond_eval
   import bcc_pkg::*;
#(
   parameter bit NV_TAKEN = 1'b0
) (
   input  logic [3:0] flags,
   input  logic [3:0] branch_cond,
   output logic       taken
);

   logic z;
   logic c;
   logic n;
   logic v;

   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign n = flags[FLAG_N];
   assign v = flags[FLAG_V];

   // Every code is decoded explicitly, so the output is defined for all inputs.
   always_comb begin
      taken = 1'b0;
      case (branch_cond)
         COND_EQ: taken = z;
         COND_NE: taken = ~z;
         COND_CS: taken = c;
         COND_CC: taken = ~c;
         COND_MI: taken = n;
         COND_PL: taken = ~n;
         COND_VS: taken = v;
         COND_VC: taken = ~v;
         COND_HI: taken = c & ~z;
         COND_LS: taken = ~c | z;
         COND_GE: taken = ~(n ^ v);
         COND_LT: taken = n ^ v;
         COND_GT: taken = ~z & ~(n ^ v);
         COND_LE: taken = z | (n ^ v);
         COND_AL: taken = 1'b1;
         COND_NV: taken = NV_TAKEN;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/bcc.sv
// bcc: registered branch condition evaluator.
// Ports:
//   clk         in        system clock, rising edge
//   rst         in        synchronous active-high reset
//   flags       in  [3:0] status flags packed {Z,C,N,V}
//   branch_cond in  [3:0] condition field of the branch instruction
//   do_branch   out       registered branch-taken decision
// Parameter:
//   NV_TAKEN    result for the NV code (0: never taken, 1: unconditional)
//
// There is no valid/ready handshake: a decision is computed on every edge and
// the fetch logic qualifies do_branch with its own branch-instruction valid.
// do_branch reflects the inputs sampled at the previous rising edge.
module bcc
   import bcc_pkg::*;
#(
   parameter bit NV_TAKEN = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] flags,
   input  logic [3:0] branch_cond,
   output logic       do_branch
);

   logic taken;

   bcc_cond_eval #(
      .NV_TAKEN(NV_TAKEN)
   ) u_cond_eval (
      .flags      (flags),
      .branch_cond(branch_cond),
      .taken      (taken)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         do_branch <= 1'b0;
      end else begin
         do_branch <= taken;
      end
   end

endmodule

// File: tb/tb_bcc.sv
// tb_bcc: bench for bcc. Two instances share the stimulus, one built with
// NV_TAKEN=0 and one with NV_TAKEN=1.
module tb_bcc;

   logic       clk;
   logic       rst;
   logic [3:0] flags;
   logic [3:0] branch_cond;
   logic       do_branch0;
   logic       do_branch1;

   int checks = 0;
   int errors = 0;

   // Expected {nv1_result, nv0_result}, one entry per rising edge.
   logic [1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   bcc #(.NV_TAKEN(1'b0)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .flags      (flags),
      .branch_cond(branch_cond),
      .do_branch  (do_branch0)
   );

   bcc #(.NV_TAKEN(1'b1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .flags      (flags),
      .branch_cond(branch_cond),
      .do_branch  (do_branch1)
   );

   // ---------------- reference model ----------------
   // Uses the architectural structure of the condition field: cond[3:1] picks
   // a predicate and cond[0] inverts it, except for the AL/NV pair.
   function automatic logic ref_eval(input logic [3:0] f, input logic [3:0] c,
                                     input logic nv);
      logic z, cf, n, v, base;
      z  = f[3];
      cf = f[2];
      n  = f[1];
      v  = f[0];
      base = 1'b0;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: return c[0] ? nv : 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   always @(posedge clk) begin
      if (rst) exp_q.push_back(2'b00);
      else     exp_q.push_back({ref_eval(flags, branch_cond, 1'b1),
                                ref_eval(flags, branch_cond, 1'b0)});
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      logic [1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (do_branch0 !== e[0]) begin
            errors++;
            $display("FAIL model_nv0 flags=%b cond=%b got=%b exp=%b",
                     flags, branch_cond, do_branch0, e[0]);
         end
         checks++;
         if (do_branch1 !== e[1]) begin
            errors++;
            $display("FAIL model_nv1 flags=%b cond=%b got=%b exp=%b",
                     flags, branch_cond, do_branch1, e[1]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_lit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   // Apply one vector, let one edge sample it, then check both instances
   // against hand-computed literals.
   task automatic apply_dir(input string name, input logic [3:0] f,
                            input logic [3:0] c, input logic e0, input logic e1);
      @(posedge clk);
      #2;
      flags       = f;
      branch_cond = c;
      @(posedge clk);
      @(negedge clk);
      check_lit({name, "_nv0"}, do_branch0, e0);
      check_lit({name, "_nv1"}, do_branch1, e1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst         = 1'b1;
      flags       = 4'b0000;
      branch_cond = 4'b1110;

      // Reset with AL pending: output held low.
      @(posedge clk);
      @(negedge clk);
      check_lit("reset_nv0", do_branch0, 1'b0);
      check_lit("reset_nv1", do_branch1, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_lit("post_reset_al_nv0", do_branch0, 1'b1);
      check_lit("post_reset_al_nv1", do_branch1, 1'b1);

      // Simple flags
      apply_dir("eq_set",   4'b1111, 4'b0000, 1'b1, 1'b1);
      apply_dir("eq_clr",   4'b0110, 4'b0000, 1'b0, 1'b0);
      apply_dir("ne",       4'b0111, 4'b0001, 1'b1, 1'b1);
      apply_dir("cs",       4'b0010, 4'b0010, 1'b0, 1'b0);
      apply_dir("mi",       4'b0110, 4'b0100, 1'b1, 1'b1);
      apply_dir("cc",       4'b1101, 4'b0011, 1'b0, 1'b0);
      apply_dir("pl",       4'b0000, 4'b0101, 1'b1, 1'b1);
      // Compound conditions
      apply_dir("hi_set",   4'b0100, 4'b1000, 1'b1, 1'b1);
      apply_dir("hi_clr",   4'b1100, 4'b1000, 1'b0, 1'b0);
      apply_dir("ge",       4'b0011, 4'b1010, 1'b1, 1'b1);
      apply_dir("lt",       4'b0010, 4'b1011, 1'b1, 1'b1);
      apply_dir("gt",       4'b1000, 4'b1100, 1'b0, 1'b0);
      apply_dir("le",       4'b0001, 4'b1101, 1'b1, 1'b1);
      // Overflow and NV
      apply_dir("vs",       4'b0001, 4'b0110, 1'b1, 1'b1);
      apply_dir("vc",       4'b0001, 4'b0111, 1'b0, 1'b0);
      apply_dir("nv",       4'b0001, 4'b1111, 1'b0, 1'b1);
      apply_dir("ls_clr",   4'b0100, 4'b1001, 1'b0, 1'b0);

      // Exhaustive back-to-back sweep, checked by the model every cycle.
      for (int i = 0; i < 256; i++) begin
         @(posedge clk);
         #2;
         flags       = 4'(i >> 4);
         branch_cond = 4'(i);
      end

      // Mid-stream reset with AL held steady.
      apply_dir("al_steady", 4'b0000, 4'b1110, 1'b1, 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_lit("mid_reset_nv0", do_branch0, 1'b0);
      check_lit("mid_reset_nv1", do_branch1, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_lit("after_mid_reset_nv0", do_branch0, 1'b1);
      check_lit("after_mid_reset_nv1", do_branch1, 1'b1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
